// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the ID/EX stage: ALU op codes, funct codes,
// main-control classes and the forwarding-match helper.
package mips_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    CLS_ADD   = 2'b00,
    CLS_SUB   = 2'b01,
    CLS_RTYPE = 2'b10,
    CLS_RSVD  = 2'b11
  } alu_class_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is hardwired, so a pending write to it must never be forwarded.
  function automatic logic fwd_hit(input logic wr, input logic [4:0] rd, input logic [4:0] src);
    return wr && (rd != REG_ZERO) && (rd == src);
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// ALU control decode: maps the main-control class and funct field to an
// ALU operation, flagging anything unrecognised as illegal.
module alu_ctrl
  import mips_pkg::*;
(
  input  logic [1:0] alu_class_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       illegal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    illegal_o = 1'b0;
    case (alu_class_i)
      CLS_ADD: alu_op_o = ALU_ADD;
      CLS_SUB: alu_op_o = ALU_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: alu_op_o = ALU_ADD;
          FUNCT_SUB: alu_op_o = ALU_SUB;
          FUNCT_AND: alu_op_o = ALU_AND;
          FUNCT_OR:  alu_op_o = ALU_OR;
          FUNCT_SLT: alu_op_o = ALU_SLT;
          default:   illegal_o = 1'b1;
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB
// and load-use hazard detection.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [1:0]  id_alu_op,
  input  logic [5:0]  id_funct,
  input  logic        id_alu_src,
  input  logic        id_reg_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [2:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dest,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_illegal,
  output logic        stall
);

  logic        valid_q, valid_d;
  logic [4:0]  rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [31:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic        alu_src_q, alu_src_d;
  logic        reg_write_q, reg_write_d, mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  dec_op;
  logic        dec_illegal;
  logic        capture;
  logic [31:0] fwd_a, fwd_b;

  alu_ctrl u_alu_ctrl (
    .alu_class_i (id_alu_op),
    .funct_i     (id_funct),
    .alu_op_o    (dec_op),
    .illegal_o   (dec_illegal)
  );

  assign stall = valid_q && mem_read_q && id_valid && (dest_q != REG_ZERO) &&
                 ((dest_q == id_rs) || (dest_q == id_rt));
  assign capture = id_valid && !stall && !flush;

  // Anything not captured becomes a bubble with every field cleared.
  always_comb begin
    valid_d      = 1'b0;
    rs_d         = '0;
    rt_d         = '0;
    dest_d       = '0;
    rs_data_d    = '0;
    rt_data_d    = '0;
    imm_d        = '0;
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    alu_op_d     = ALU_ADD;
    illegal_d    = 1'b0;
    if (capture) begin
      valid_d      = 1'b1;
      rs_d         = id_rs;
      rt_d         = id_rt;
      dest_d       = id_reg_dst ? id_rd : id_rt;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      alu_src_d    = id_alu_src;
      reg_write_d  = id_reg_write && !dec_illegal;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write && !dec_illegal;
      mem_to_reg_d = id_mem_to_reg;
      alu_op_d     = dec_op;
      illegal_d    = dec_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_op_q     <= ALU_ADD;
      illegal_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_op_q     <= alu_op_d;
      illegal_q    <= illegal_d;
    end
  end

  // The younger EX/MEM result wins over MEM/WB when both target the register.
  always_comb begin
    if (fwd_hit(exmem_reg_write, exmem_rd, rs_q))      fwd_a = exmem_result;
    else if (fwd_hit(memwb_reg_write, memwb_rd, rs_q)) fwd_a = memwb_result;
    else                                               fwd_a = rs_data_q;
    if (fwd_hit(exmem_reg_write, exmem_rd, rt_q))      fwd_b = exmem_result;
    else if (fwd_hit(memwb_reg_write, memwb_rd, rt_q)) fwd_b = memwb_result;
    else                                               fwd_b = rt_data_q;
  end

  assign alu_op        = alu_op_q;
  assign alu_a         = fwd_a;
  assign alu_b         = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_dest       = dest_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard testbench for id_ex_stage: a driver pushes expected outputs from
// a behavioural model into a queue, a monitor pops and compares every cycle.
module tb_id_ex_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, id_valid, flush;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal, stall;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_illegal(ex_illegal), .stall(stall)
  );

  typedef struct {
    logic        reset, id_valid, flush;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  cls;
    logic [5:0]  funct;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic        exmem_rw, memwb_rw;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_res, memwb_res;
  } stim_t;

  // Abstract contents of the EX stage as the reference model sees them.
  typedef struct {
    logic        valid, fromReset;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src, reg_write, mem_read, mem_write, mem_to_reg, illegal;
    logic [2:0]  op;
  } ex_t;

  typedef struct {
    logic        checkData, stall, valid, reg_write, mem_read, mem_write, mem_to_reg, illegal;
    logic [4:0]  dest;
    logic [2:0]  op;
    logic [31:0] a, b, store;
  } exp_t;

  exp_t sbQueue[$];
  exp_t monExp;
  ex_t  model;
  int   nChecks = 0;
  int   nFails  = 0;
  int   cycle   = 0;

  logic [5:0] legalFunct [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  logic [2:0] legalOp    [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

  always @(posedge clk) cycle++;

  function automatic ex_t bubble(input logic fromReset);
    ex_t b;
    b = '{default: '0};
    b.op = 3'b010;
    b.fromReset = fromReset;
    return b;
  endfunction

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [31:0] rsd, input logic [31:0] rtd, input logic [5:0] f);
    stim_t s = idleStim();
    s.id_valid = 1'b1; s.rs = rs; s.rt = rt; s.rd = rd; s.rs_data = rsd; s.rt_data = rtd;
    s.cls = 2'b10; s.funct = f; s.reg_dst = 1'b1; s.reg_write = 1'b1;
    return s;
  endfunction

  function automatic stim_t loadWord(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
    stim_t s = idleStim();
    s.id_valid = 1'b1; s.rs = rs; s.rt = rt; s.imm = imm; s.cls = 2'b00; s.alu_src = 1'b1;
    s.reg_write = 1'b1; s.mem_read = 1'b1; s.mem_to_reg = 1'b1; s.rs_data = 32'h1000;
    return s;
  endfunction

  function automatic logic [31:0] forwarded(input logic [4:0] r, input logic [31:0] regVal, input stim_t s);
    if (s.exmem_rw && r != 0 && s.exmem_rd == r) return s.exmem_res;
    if (s.memwb_rw && r != 0 && s.memwb_rd == r) return s.memwb_res;
    return regVal;
  endfunction

  function automatic ex_t nextState(input ex_t cur, input stim_t s, input logic stallNow);
    ex_t n;
    if (s.reset) return bubble(1'b1);
    if (stallNow || s.flush || !s.id_valid) return bubble(1'b0);
    n = bubble(1'b0);
    n.valid = 1'b1; n.rs = s.rs; n.rt = s.rt; n.dest = s.reg_dst ? s.rd : s.rt;
    n.rs_data = s.rs_data; n.rt_data = s.rt_data; n.imm = s.imm; n.alu_src = s.alu_src;
    n.mem_read = s.mem_read; n.mem_to_reg = s.mem_to_reg;
    n.illegal = 1'b1;
    if (s.cls == 2'b00) begin n.op = 3'b010; n.illegal = 1'b0; end
    else if (s.cls == 2'b01) begin n.op = 3'b110; n.illegal = 1'b0; end
    else if (s.cls == 2'b10)
      for (int i = 0; i < 5; i++)
        if (s.funct == legalFunct[i]) begin n.op = legalOp[i]; n.illegal = 1'b0; end
    n.reg_write = s.reg_write && !n.illegal;
    n.mem_write = s.mem_write && !n.illegal;
    if (cur.valid) n.fromReset = 1'b0;
    return n;
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic [31:0] fb;
    @(negedge clk);
    reset = s.reset; id_valid = s.id_valid; flush = s.flush;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_alu_op = s.cls; id_funct = s.funct;
    id_alu_src = s.alu_src; id_reg_dst = s.reg_dst; id_reg_write = s.reg_write;
    id_mem_read = s.mem_read; id_mem_write = s.mem_write; id_mem_to_reg = s.mem_to_reg;
    exmem_reg_write = s.exmem_rw; exmem_rd = s.exmem_rd; exmem_result = s.exmem_res;
    memwb_reg_write = s.memwb_rw; memwb_rd = s.memwb_rd; memwb_result = s.memwb_res;
    if (s.reset) model = bubble(1'b1);
    e.stall = model.valid && model.mem_read && s.id_valid && model.dest != 0 &&
              (model.dest == s.rs || model.dest == s.rt);
    e.checkData = model.valid || model.fromReset;
    e.valid = model.valid; e.reg_write = model.reg_write; e.mem_read = model.mem_read;
    e.mem_write = model.mem_write; e.mem_to_reg = model.mem_to_reg; e.illegal = model.illegal;
    e.dest = model.dest; e.op = model.op;
    e.a = forwarded(model.rs, model.rs_data, s);
    fb = forwarded(model.rt, model.rt_data, s);
    e.b = model.alu_src ? model.imm : fb;
    e.store = fb;
    sbQueue.push_back(e);
    model = nextState(model, s, e.stall);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cycle, act, expv);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (sbQueue.size() > 0) begin
        monExp = sbQueue.pop_front();
        checkOutput("stall", 32'(stall), 32'(monExp.stall));
        checkOutput("ex_valid", 32'(ex_valid), 32'(monExp.valid));
        checkOutput("ex_reg_write", 32'(ex_reg_write), 32'(monExp.reg_write));
        checkOutput("ex_mem_read", 32'(ex_mem_read), 32'(monExp.mem_read));
        checkOutput("ex_mem_write", 32'(ex_mem_write), 32'(monExp.mem_write));
        checkOutput("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(monExp.mem_to_reg));
        checkOutput("ex_illegal", 32'(ex_illegal), 32'(monExp.illegal));
        checkOutput("ex_dest", 32'(ex_dest), 32'(monExp.dest));
        checkOutput("alu_op", 32'(alu_op), 32'(monExp.op));
        if (monExp.checkData) begin
          checkOutput("alu_a", alu_a, monExp.a);
          checkOutput("alu_b", alu_b, monExp.b);
          checkOutput("ex_store_data", ex_store_data, monExp.store);
        end
      end
    end
  end

  initial begin
    stim_t s;
    model = bubble(1'b1);
    // Reset held with a valid instruction waiting, then first capture.
    s = rType(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 6'b100000);
    s.reset = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s.reset = 1'b0;
    applyStimulus(s);
    applyStimulus(idleStim());
    // Forwarding priority on rs, then $zero never forwarded and MEM/WB-only on rt.
    applyStimulus(rType(5'd1, 5'd9, 5'd8, 32'h99, 32'h3, 6'b100010));
    s = idleStim();
    s.exmem_rw = 1'b1; s.exmem_rd = 5'd1; s.exmem_res = 32'h10;
    s.memwb_rw = 1'b1; s.memwb_rd = 5'd1; s.memwb_res = 32'h20;
    applyStimulus(s);
    applyStimulus(rType(5'd0, 5'd2, 5'd7, 32'h55, 32'h66, 6'b101010));
    s = idleStim();
    s.exmem_rw = 1'b1; s.exmem_rd = 5'd0; s.exmem_res = 32'hdead;
    s.memwb_rw = 1'b1; s.memwb_rd = 5'd2; s.memwb_res = 32'h77;
    applyStimulus(s);
    // Load-use: lw $4 then add $5,$4,$6 held in ID across the stall.
    applyStimulus(loadWord(5'd1, 5'd4, 32'h8));
    s = rType(5'd4, 5'd6, 5'd5, 32'h1, 32'h2, 6'b100000);
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());
    // Flush of a valid sub, then an illegal funct.
    s = rType(5'd2, 5'd3, 5'd4, 32'h9, 32'h4, 6'b000000);
    s.cls = 2'b01; s.flush = 1'b1;
    applyStimulus(s);
    s = rType(5'd2, 5'd3, 5'd4, 32'h9, 32'h4, 6'b000111);
    s.mem_write = 1'b1;
    applyStimulus(s);
    applyStimulus(idleStim());
    // Reset arriving while a load-use stall is pending.
    applyStimulus(loadWord(5'd2, 5'd4, 32'h4));
    s = rType(5'd4, 5'd6, 5'd5, 32'h1, 32'h2, 6'b100000);
    s.reset = 1'b1;
    applyStimulus(s);
    s.reset = 1'b0;
    applyStimulus(s);
    for (int i = 0; i < 400; i++) begin
      s = idleStim();
      s.reset = ($urandom_range(0, 79) == 0);
      s.id_valid = ($urandom_range(0, 9) != 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7)); s.rd = 5'($urandom_range(0, 7));
      s.rs_data = $urandom; s.rt_data = $urandom; s.imm = $urandom;
      s.cls = 2'($urandom_range(0, 3));
      s.funct = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legalFunct[$urandom_range(0, 4)];
      s.alu_src = 1'($urandom); s.reg_dst = 1'($urandom); s.reg_write = 1'($urandom);
      s.mem_read = ($urandom_range(0, 2) == 0); s.mem_write = 1'($urandom); s.mem_to_reg = 1'($urandom);
      s.exmem_rw = 1'($urandom); s.exmem_rd = 5'($urandom_range(0, 7)); s.exmem_res = $urandom;
      s.memwb_rw = 1'($urandom); s.memwb_rd = 5'($urandom_range(0, 7)); s.memwb_res = $urandom;
      applyStimulus(s);
    end
    applyStimulus(idleStim());
    repeat (2) @(negedge clk);
    #4;
    checkOutput("queue_drain", 32'(sbQueue.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-high; clears all state.
REQ-003 SHALL provide: id_valid  input  1  decode stage holds a real instruction.
REQ-004 SHALL provide: id_rs_data, id_rt_data, id_imm  input  32 each  register-file reads, sign-extended immediate.
REQ-005 SHALL provide: id_rs, id_rt, id_rd  input  5 each  register specifiers.
REQ-006 SHALL provide: id_alu_op  input  2  main-control class (00 add, 01 sub, 10 R-type, 11 reserved); id_funct  input  6.
REQ-007 SHALL provide: id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  input  1 each.
REQ-008 SHALL provide: flush  input  1  squash the instruction being captured.
REQ-009 SHALL provide: exmem_reg_write  input  1, exmem_rd  input  5, exmem_result  input  32; memwb_reg_write, memwb_rd, memwb_result likewise.
REQ-010 SHALL provide: alu_op  output  3, alu_a  output  32, alu_b  output  32  ALU operands and operation.
REQ-011 SHALL provide: ex_store_data  output  32, ex_dest  output  5, ex_valid  output  1, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  output  1 each, ex_illegal  output  1.
REQ-012 SHALL provide: stall  output  1  load-use hazard; freezes PC and IF/ID.

Function
REQ-013 SHALL capture all id_* fields on each rising edge when neither stall nor flush is asserted.
REQ-014 SHALL capture a bubble when stall=1 or flush=1 (flush and stall together: bubble): ex_valid=0, all ex_* control=0, ex_dest=0, alu_op=010, ex_illegal=0.
REQ-015 SHALL capture a bubble when id_valid=0.
REQ-016 SHALL decode alu_op at capture: class 00 -> 010; 01 -> 110; 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
REQ-017 SHALL, for class 10 with any other funct or class 11, register alu_op=010, ex_illegal=1, ex_reg_write=0, ex_mem_write=0.
REQ-018 SHALL register ex_dest = id_reg_dst ? id_rd : id_rt.
REQ-019 SHALL compute forwarded A combinationally from registered rs: exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs; else memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs; else registered rs_data.
REQ-020 SHALL compute forwarded B identically using registered rt; EX/MEM has priority over MEM/WB.
REQ-021 SHALL drive alu_a = forwarded A; alu_b = alu_src ? registered imm : forwarded B; ex_store_data = forwarded B.
REQ-022 SHALL assert stall combinationally when ex_valid & ex_mem_read & id_valid & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
REQ-023 SHALL hold stall exactly one cycle per load-use pair (bubble clears ex_mem_read).
REQ-024 SHALL never forward or stall on register 0.
REQ-025 SHALL have one-cycle latency from id_* capture to alu_* outputs; forwarding adds zero latency.

Reset
REQ-026 SHALL, while reset=1, asynchronously clear all registered fields to 0 except alu_op=010.
REQ-027 SHALL yield after reset: ex_valid=0, all ex_* control=0, ex_dest=0, ex_illegal=0, stall=0, alu_a=0, alu_b=0, ex_store_data=0 (registered rs/rt=0, so no forwarding).
REQ-028 SHALL, on reset asserted mid-stall, drop stall immediately and discard the held instruction.

Structure
REQ-029 SHALL place ALU op codes (AND 000, OR 001, ADD 010, SUB 110, SLT 111), funct codes and main-control class codes in shared package mips_pkg.
REQ-030 SHALL isolate the REQ-016/017 decode in one combinational sub-module alu_ctrl.

Verification
REQ-031 Reset with reset=1, id_valid=1 -> all outputs per REQ-027; first edge after release captures instruction.
REQ-032 R-type add $3,$1,$2, rs_data=5, rt_data=7, funct 100000 -> next cycle alu_op=010, alu_a=5, alu_b=7, ex_dest=3.
REQ-033 EX/MEM rd=1 result=0x10 and MEM/WB rd=1 result=0x20, ex rs=1 -> alu_a=0x10; EX/MEM rd=0 with rs=0 -> no forward.
REQ-034 lw $4 in EX, add $5,$4,$6 in ID -> stall=1 one cycle, bubble captured, add captured next edge, stall=0.
REQ-035 flush=1 with valid sub in ID -> next cycle ex_valid=0, alu_op=010, all control 0.
REQ-036 class 10, funct 000111 -> ex_illegal=1, alu_op=010, ex_reg_write=0.
